// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and default widths for program_loader and program_ram
package loader_pkg;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int CHK_MOD = 2 ** DEF_DATA_WIDTH;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;
endpackage

// File: rtl/program_ram.sv
// program_ram: 2**ADDR_WIDTH x DATA_WIDTH RAM; ports clk, rst_n (async clear all words), we/waddr/wdata (sync write), raddr/rdata (async read)
module program_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/program_loader.sv
// program_loader: streams LEN+1 bytes into program RAM and holds the CPU in reset until loaded (checksum byte verified when PROGRAM_LOADER_CHECKSUM_EN); ports clk, rst_n, start, len, in_data/in_valid/in_ready, addr/data read port, cpu_rst, busy, done, err
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, len_q;
  logic xfer, idle_like;
  assign xfer = in_valid && in_ready;
  assign idle_like = state == S_IDLE || state == S_RUN || state == S_ERROR;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum <= '0;
    else if (start && idle_like) sum <= '0;
    else if (xfer && state == S_LOAD) sum <= sum + in_data;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      len_q <= '0;
    end else begin
      state <= state_n;
      if (start && idle_like) begin
        ptr   <= '0;
        len_q <= len;
      end else if (xfer && state == S_LOAD) ptr <= ptr + 1'b1;
    end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_RUN, S_ERROR: if (start) state_n = S_LOAD;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_LOAD:  if (xfer && ptr == len_q) state_n = S_CHECK;
      S_CHECK: if (xfer) state_n = DATA_WIDTH'(sum + in_data) == '0 ? S_RUN : S_ERROR;
`else
      S_LOAD:  if (xfer && ptr == len_q) state_n = S_RUN;
`endif
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    in_ready = state == S_LOAD || state == S_CHECK;
    busy     = in_ready;
    done     = state == S_RUN;
    cpu_rst  = state != S_RUN;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    err      = state == S_ERROR;
`else
    err      = 1'b0;
`endif
  end
  program_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (xfer && state == S_LOAD),
    .waddr (ptr),
    .wdata (in_data),
    .raddr (addr),
    .rdata (data)
  );
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed table-driven checks of program_loader plus backpressure, ignored-start and async-reset sequences
module tb_program_loader;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [3:0] len = '0, addr = '0;
  logic [7:0] in_data = '0;
  logic in_ready, cpu_rst, busy, done, err;
  logic [7:0] data;
  int total = 0, passed = 0;
  typedef struct {
    logic       s;
    logic [3:0] l;
    logic [7:0] d;
    logic       v;
    logic [3:0] a;
    logic       rdy, bsy, dn, er, cr;
    logic [7:0] q;
  } vec_t;
  vec_t tbl[$];
  program_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .addr(addr), .data(data),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  task automatic add(input logic s, input logic [3:0] l, input logic [7:0] d, input logic v,
                     input logic [3:0] a, input logic rdy, input logic bsy, input logic dn,
                     input logic er, input logic cr, input logic [7:0] q);
    tbl.push_back('{s, l, d, v, a, rdy, bsy, dn, er, cr, q});
  endtask
  task automatic apply(input vec_t t, input string tag);
    start = t.s; len = t.l; in_data = t.d; in_valid = t.v; addr = t.a;
    #1;
    chk({tag, ".in_ready"}, {7'd0, in_ready}, {7'd0, t.rdy});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, t.bsy});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, t.dn});
    chk({tag, ".err"}, {7'd0, err}, {7'd0, t.er});
    chk({tag, ".cpu_rst"}, {7'd0, cpu_rst}, {7'd0, t.cr});
    chk({tag, ".data"}, data, t.q);
    @(posedge clk); #1;
  endtask
  initial begin
    logic [7:0] bytes [17];
    int nbytes, idx, cyc;
    // good load: LEN=1, bytes 12 34 (checksum BA)
    add(1, 1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    add(0, 0, 8'h12, 1, 0, 1, 1, 0, 0, 1, 8'h00);
    add(0, 0, 8'h34, 1, 0, 1, 1, 0, 0, 1, 8'h12);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add(0, 0, 8'hBA, 1, 1, 1, 1, 0, 0, 1, 8'h34);
`endif
    add(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h34);
    add(0, 0, 8'h00, 0, 2, 0, 0, 1, 0, 0, 8'h00);
    add(1, 1, 8'h55, 1, 0, 0, 0, 1, 0, 0, 8'h12);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    add(0, 0, 8'h12, 1, 0, 1, 1, 0, 0, 1, 8'h12);
    add(0, 0, 8'h34, 1, 1, 1, 1, 0, 0, 1, 8'h34);
    add(0, 0, 8'hBB, 1, 1, 1, 1, 0, 0, 1, 8'h34);
    add(0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 8'h12);
    add(1, 1, 8'h00, 0, 0, 0, 0, 0, 1, 1, 8'h12);
    add(0, 0, 8'h12, 1, 0, 1, 1, 0, 0, 1, 8'h12);
    add(0, 0, 8'h34, 1, 0, 1, 1, 0, 0, 1, 8'h12);
    add(0, 0, 8'hBA, 1, 1, 1, 1, 0, 0, 1, 8'h34);
    add(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h34);
`else
    add(0, 0, 8'hA0, 1, 0, 1, 1, 0, 0, 1, 8'h12);
    add(0, 0, 8'h05, 1, 0, 1, 1, 0, 0, 1, 8'hA0);
    add(0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h05);
    add(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'hA0);
`endif
    #2 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1 chk($sformatf("reset.mem%0d", i), data, 8'h00);
    end
    chk("reset.cpu_rst", {7'd0, cpu_rst}, 8'h01);
    chk("reset.in_ready", {7'd0, in_ready}, 8'h00);
    chk("reset.done", {7'd0, done}, 8'h00);
    chk("reset.err", {7'd0, err}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));
    // backpressure: LEN=15, bytes 0..15, checksum 0x88, random valid gaps
    for (int i = 0; i < 16; i++) bytes[i] = 8'(i);
    bytes[16] = 8'h88;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    nbytes = 17;
`else
    nbytes = 16;
`endif
    start = 1'b1; len = 4'hF; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < nbytes && cyc < 400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = bytes[idx];
      #1;
      if (in_ready !== 1'b1) chk($sformatf("bp.in_ready%0d", idx), {7'd0, in_ready}, 8'h01);
      if (in_valid) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("bp.accepted", 8'(idx), 8'(nbytes));
    chk("bp.done", {7'd0, done}, 8'h01);
    chk("bp.cpu_rst", {7'd0, cpu_rst}, 8'h00);
    chk("bp.err", {7'd0, err}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1 chk($sformatf("bp.mem%0d", i), data, 8'(i));
    end
    // async reset from RUN raises cpu_rst before any clock edge
    @(posedge clk); #2;
    addr = 4'd5;
    rst_n = 1'b0;
    #1;
    chk("arst.cpu_rst", {7'd0, cpu_rst}, 8'h01);
    chk("arst.done", {7'd0, done}, 8'h00);
    chk("arst.mem5", data, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    // START during LOAD is ignored; reset after 5 bytes clears everything
    apply('{1, 4'hF, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h00}, "ig0");
    apply('{0, 4'h0, 8'hA1, 1, 0, 1, 1, 0, 0, 1, 8'h00}, "ig1");
    apply('{0, 4'h0, 8'hA2, 1, 0, 1, 1, 0, 0, 1, 8'hA1}, "ig2");
    apply('{0, 4'h0, 8'hA3, 1, 1, 1, 1, 0, 0, 1, 8'hA2}, "ig3");
    apply('{1, 4'h1, 8'h00, 0, 2, 1, 1, 0, 0, 1, 8'hA3}, "ig4");
    apply('{0, 4'h0, 8'hA4, 1, 0, 1, 1, 0, 0, 1, 8'hA1}, "ig5");
    apply('{0, 4'h0, 8'hA5, 1, 3, 1, 1, 0, 0, 1, 8'hA4}, "ig6");
    apply('{0, 4'h0, 8'h00, 0, 4, 1, 1, 0, 0, 1, 8'hA5}, "ig7");
    addr = 4'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid.mem0", data, 8'h00);
    chk("mid.cpu_rst", {7'd0, cpu_rst}, 8'h01);
    chk("mid.busy", {7'd0, busy}, 8'h00);
    chk("mid.in_ready", {7'd0, in_ready}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    apply('{0, 4'h0, 8'h77, 1, 4, 0, 0, 0, 0, 1, 8'h00}, "post");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the program store. It accepts a byte stream over a valid/ready handshake and writes it into an internal 16x8 program RAM.
- The RAM's combinational read port replaces the fixed ROM feeding the instruction decoder; the program counter drives the read address.
- The block holds the processor in reset while loading and releases it only after a successful load. With checksum enabled, success also requires a verified checksum.

Parameters:
- ADDR_WIDTH, 4, program address width; RAM depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, instruction width: opcode in [7:4], immediate in [3:0].

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  single-cycle pulse; begins a load at address 0.
- LEN  input  ADDR_WIDTH  last address to load; byte count = LEN+1; sampled on accepted START.
- IN_DATA  input  DATA_WIDTH  stream byte.
- IN_VALID  input  1  IN_DATA valid.
- IN_READY  output  1  loader accepts a byte this cycle.
- ADDR  input  ADDR_WIDTH  read address from program counter.
- DATA  output  DATA_WIDTH  mem[ADDR], combinational.
- CPU_RST  output  1  active-high reset to the program counter; OR with system reset at top level.
- BUSY  output  1  state is LOAD or CHECK.
- DONE  output  1  state is RUN.
- ERR  output  1  state is ERROR.

Behaviour:
- **States:** IDLE, LOAD, CHECK, RUN, ERROR. State, write pointer, checksum accumulator and latched length are registered. All outputs are decoded from registered state only.
- **Reset (RST_N low, asynchronous):**
  - state=IDLE, ptr=0, sum=0, len_q=0.
  - All RAM words = 0x00.
  - Outputs: CPU_RST=1, IN_READY=0, BUSY=0, DONE=0, ERR=0.
- **Transfer rule:** a transfer occurs on a rising edge with IN_VALID=1 and IN_READY=1. IN_READY=1 only in LOAD and CHECK. The source must hold IN_DATA stable while IN_VALID=1 and IN_READY=0.
- **IDLE:** CPU_RST=1. START=1 → LOAD; ptr<=0, sum<=0, len_q<=LEN.
- **LOAD:**
  - On transfer: mem[ptr]<=IN_DATA, sum<=sum+IN_DATA (mod 2**DATA_WIDTH), ptr<=ptr+1.
  - If ptr==len_q on that transfer → CHECK. ptr wraps to 0 when LEN=max; the wrap is harmless.
- **CHECK:** the next transfer is the checksum byte and is not written to RAM.
  - If (sum+IN_DATA) mod 256 == 0 → RUN.
  - Otherwise → ERROR.
- **RUN:** CPU_RST=0, DONE=1. CPU_RST falls on the edge after the checksum transfer, so the processor sees its first unreset edge one cycle later.
- **ERROR:** CPU_RST=1, ERR=1. The RAM keeps its partial or incorrect contents.
- **START handling:** START in RUN or ERROR → LOAD, same actions as from IDLE (CPU_RST reasserts on that edge, ERR/DONE clear). START in LOAD or CHECK is ignored.
- **Read port:** valid in every state. A written word is visible on DATA the cycle after its transfer edge. Words at addresses > len_q keep their previous contents.
- **Simultaneous events:** START together with IN_VALID in IDLE/RUN/ERROR — the byte is not accepted (IN_READY=0 that cycle).
- **RST_N mid-load:** abort immediately to the reset values above.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- **Defined:** CHECK state and sum accumulator present, as described above.
- **Undefined:** no CHECK state and no accumulator. The last LOAD transfer goes directly to RUN. ERROR is unreachable and ERR is tied 0.

Decomposition:
- Shared package loader_pkg: state encoding constants (IDLE=0, LOAD=1, CHECK=2, RUN=3, ERROR=4; 3 bits), default ADDR_WIDTH/DATA_WIDTH, checksum modulus constant.
- One sub-module: program_ram.
  - Parameterised depth/width.
  - Synchronous write enable with address and data.
  - Asynchronous read.
  - Asynchronous active-low clear of all words.
  - The loader FSM instantiates it.

Test Plan:
- **Reset:** hold RST_N=0 with ADDR=0..15 → DATA=0x00 everywhere; CPU_RST=1, IN_READY=0, DONE=ERR=0.
- **Good load:** START with LEN=1, stream 0x12, 0x34, checksum 0xBA, IN_VALID always high.
  - IN_READY high 3 cycles, DONE=1 the edge after the third transfer, CPU_RST=0.
  - mem[0]=0x12, mem[1]=0x34, mem[2..15] unchanged.
- **Bad checksum:** same bytes, checksum 0xBB → ERR=1, CPU_RST=1, DONE=0. A following START clears ERR and sets BUSY=1 next cycle.
- **Backpressure and gaps:** LEN=15, 16 bytes 0x00..0x0F plus checksum 0x88, IN_VALID toggled randomly → exactly 16 RAM writes in order, ptr wraps, RUN reached, mem[i]=i.
- **Ignored START and reset mid-load:** START pulsed during LOAD → no pointer reset. RST_N pulsed low after 5 bytes → IDLE, RAM cleared, CPU_RST=1 asynchronously (before the next clock edge).
- **Checksum disabled (macro undefined):** LEN=1, bytes 0xA0, 0x05 → RUN right after the second transfer, ERR stays 0.
